multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 1, meaning the number of cycles spent in IDLE after reset release (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port opcode, input, 6 bits: instruction bits [31:26] from the instruction register.
REQ-006 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-008 SHALL have port wr_inhibit, input, 1 bit: forces RegWrite to 0 while high.
REQ-009 SHALL have port Start_PC, output, 1 bit: 0 in IDLE, 1 in every other state.
REQ-010 SHALL have ports IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA and PCEn, each an output of 1 bit: datapath controls.
REQ-011 SHALL have ports ALUSrcB, ALUOp and PCSrc, each an output of 2 bits: datapath mux and ALU selects.
REQ-012 SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unknown opcode.
REQ-013 SHALL have port state_o, output, 4 bits: current state encoding, for debug.
REQ-014 SHALL have port retired, output, CNT_W bits: count of completed instructions.

Function
REQ-015 SHALL use these state encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12; encodings 13-15 SHALL go to FETCH on the next cycle with all write controls at 0.
REQ-016 SHALL remain in IDLE for exactly IDLE_CYCLES cycles, counted from the first rising edge after reset deasserts, then enter FETCH.
REQ-017 SHALL decode these opcodes: R-type=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
REQ-018 SHALL sequence states as follows:
- FETCH goes to DECODE when mem_ready=1; otherwise it stays in FETCH.
- DECODE goes to MEMADR for LW or SW, EXEC for R-type, BRANCH for BEQ, ADDIEX for ADDI, JUMP for J.
- MEMADR goes to MEMRD for LW and to MEMWR for SW.
- MEMRD goes to MEMWB when mem_ready=1; otherwise it holds.
- MEMWR goes to FETCH when mem_ready=1; otherwise it holds.
- EXEC goes to ALUWB, and ADDIEX goes to ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP each go to FETCH.
REQ-019 SHALL, in DECODE with any other opcode, return to FETCH, pulse illegal_op for one cycle, and assert no write control.
REQ-020 SHALL drive Moore outputs per state; any signal not listed for a state is 0:
- FETCH: ALUSrcB=01, IRWrite=mem_ready, PCWrite=mem_ready.
- DECODE: ALUSrcB=11.
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=1 for every cycle until mem_ready.
- EXEC: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
- JUMP: PCSrc=10, PCWrite=1.
- IDLE: all outputs 0.
REQ-021 SHALL compute PCEn = PCWrite OR (Branch AND zero) combinationally, with no added latency.
REQ-022 SHALL drive RegWrite = stateRegWrite AND NOT wr_inhibit combinationally; the FSM sequence is not affected by wr_inhibit.
REQ-023 SHALL increment retired by 1 on each transition into FETCH from MEMWB, ALUWB, ADDIWB, MEMWR, BRANCH or JUMP, wrapping modulo 2^CNT_W; illegal opcodes SHALL NOT count.
REQ-024 SHALL take exactly these cycle counts per instruction, with zero wait states: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3; each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Reset
REQ-025 SHALL, while reset=0, force the state to IDLE, clear the idle counter and retired to 0, and drive all outputs to 0, asynchronously.
REQ-026 SHALL, on reset assertion mid-instruction (including during a MEMWR wait), drop MemWrite and RegWrite in the same cycle with no completing write.

Verification
REQ-027 SHALL verify: IDLE_CYCLES=3, reset released, mem_ready=1 -> Start_PC=0 for 3 cycles, then 1; state_o=1 on the 4th edge.
REQ-028 SHALL verify: LW then R-type then ADDI, mem_ready=1 -> state_o sequences 1,2,3,4,5 / 1,2,7,8 / 1,2,10,11; retired reaches 3; RegWrite is high only in states 5, 8 and 11.
REQ-029 SHALL verify: BEQ with zero=1, then BEQ with zero=0 -> PCEn=1 and PCSrc=01 in the first BRANCH cycle; PCEn=0 in the second.
REQ-030 SHALL verify: SW with mem_ready held 0 for 2 cycles in MEMWR -> MemWrite=1 for 3 cycles, then FETCH; retired +1.
REQ-031 SHALL verify: opcode=111111 in DECODE -> illegal_op high for 1 cycle, next state FETCH, retired unchanged.
REQ-032 SHALL verify: wr_inhibit=1 during ALUWB, then reset=0 asserted in MEMWR -> RegWrite=0 with state still advancing; all outputs go to 0 immediately on reset.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control unit: Moore FSM that drives the datapath controls.
// It also counts retired instructions and flags unknown opcodes.
module multicycle_control_unit #(
  parameter int unsigned IDLE_CYCLES = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             wr_inhibit,
  output logic             Start_PC,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             PCEn,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [7:0] IdleLast = 8'(IDLE_CYCLES);

  state_e           state_q, state_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             pc_write, branch, reg_write_s;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    retire      = 1'b0;
    illegal_op  = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    reg_write_s = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSrc       = 2'b00;

    case (state_q)
      StIdle: begin
        if (idle_cnt_q == IdleLast) state_d = StFetch;
        else                        idle_cnt_d = idle_cnt_q + 8'd1;
      end
      StFetch: begin
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRType:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        IorD = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        MemtoReg    = 1'b1;
        reg_write_s = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StMemWr: begin
        // Write strobe stays up through the wait states, including the completing cycle.
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegDst      = 1'b1;
        reg_write_s = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StBranch: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        reg_write_s = 1'b1;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StJump: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      // Unused encodings recover to FETCH with every control low.
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idle_cnt_q <= 8'd0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign RegWrite = reg_write_s & ~wr_inhibit;
  assign PCEn     = pc_write | (branch & zero);
  assign Start_PC = (state_q != StIdle);
  assign state_o  = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with IDLE_CYCLES=3; expected control
// vectors are hand-derived per state.
module tb_multicycle_control_unit;

  localparam int unsigned CntW = 16;

  // Control vector order:
  // {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, ALUSrcB, ALUOp, PCSrc}
  localparam logic [13:0] CZero   = 14'b00000000_000000;
  localparam logic [13:0] CFetch  = 14'b00100001_010000;
  localparam logic [13:0] CFetchW = 14'b00000000_010000;
  localparam logic [13:0] CDecode = 14'b00000000_110000;
  localparam logic [13:0] CMemAdr = 14'b00000010_100000;
  localparam logic [13:0] CMemRd  = 14'b10000000_000000;
  localparam logic [13:0] CMemWb  = 14'b00001100_000000;
  localparam logic [13:0] CMemWr  = 14'b11000000_000000;
  localparam logic [13:0] CExec   = 14'b00000010_001000;
  localparam logic [13:0] CAluWb  = 14'b00010100_000000;
  localparam logic [13:0] CAddiWb = 14'b00000100_000000;
  localparam logic [13:0] CBr1    = 14'b00000011_000101;
  localparam logic [13:0] CBr0    = 14'b00000010_000101;
  localparam logic [13:0] CJump   = 14'b00000001_000010;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpAddi = 6'b001000, OpJ = 6'b000010;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b1, wr_inhibit = 1'b0;
  logic Start_PC, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic illegal_op;
  logic [3:0] state_o;
  logic [CntW-1:0] retired;
  logic [13:0] ctl;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.IDLE_CYCLES(3), .CNT_W(CntW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .wr_inhibit(wr_inhibit), .Start_PC(Start_PC), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .PCEn(PCEn), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .state_o(state_o), .retired(retired)
  );

  assign ctl = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn,
                ALUSrcB, ALUOp, PCSrc};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({state_o, Start_PC, ctl} !== {4'd0, 1'b0, CZero}) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", {state_o, Start_PC, ctl},
                         {4'd0, 1'b0, CZero});
    end
    checks++; if (retired !== '0) begin
      errors++; $display("FAIL reset_retired: got %0d expected 0", retired);
    end
    step();
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if ({state_o, Start_PC} !== 5'b0000_0) begin
        errors++; $display("FAIL idle_cycle%0d: state %0d start_pc %b expected 0/0", i, state_o,
                           Start_PC);
      end
    end
    step();
    checks++; if ({state_o, Start_PC, ctl} !== {4'd1, 1'b1, CFetch}) begin
      errors++; $display("FAIL idle_exit: got %h expected %h", {state_o, Start_PC, ctl},
                         {4'd1, 1'b1, CFetch});
    end
  endtask

  task automatic test_lw_r_addi();
    logic [3:0]  seq  [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd7, 4'd8,
                               4'd1, 4'd2, 4'd10, 4'd11};
    logic [5:0]  ops  [13] = '{OpLw, OpLw, OpLw, OpLw, OpLw, OpR, OpR, OpR, OpR,
                               OpAddi, OpAddi, OpAddi, OpAddi};
    logic [13:0] ctls [13] = '{CFetch, CDecode, CMemAdr, CMemRd, CMemWb, CFetch, CDecode,
                               CExec, CAluWb, CFetch, CDecode, CMemAdr, CAddiWb};
    logic rw_exp;
    for (int k = 0; k < 13; k++) begin
      opcode = ops[k];
      #1;
      rw_exp = (seq[k] == 4'd5) || (seq[k] == 4'd8) || (seq[k] == 4'd11);
      checks++; if ({state_o, ctl} !== {seq[k], ctls[k]}) begin
        errors++; $display("FAIL seq_step%0d: got state %0d ctl %b expected state %0d ctl %b",
                           k, state_o, ctl, seq[k], ctls[k]);
      end
      checks++; if (RegWrite !== rw_exp) begin
        errors++; $display("FAIL seq_regwrite%0d: got %b expected %b", k, RegWrite, rw_exp);
      end
      step();
    end
    checks++; if ({state_o, retired} !== {4'd1, CntW'(3)}) begin
      errors++; $display("FAIL seq_retired: state %0d retired %0d expected 1/3", state_o, retired);
    end
  endtask

  task automatic test_branch_jump();
    opcode = OpBeq; zero = 1'b1;
    step(); step();
    checks++; if ({state_o, ctl} !== {4'd9, CBr1}) begin
      errors++; $display("FAIL beq_taken: got %h expected %h", {state_o, ctl}, {4'd9, CBr1});
    end
    step();
    zero = 1'b0;
    step(); step();
    checks++; if ({state_o, ctl} !== {4'd9, CBr0}) begin
      errors++; $display("FAIL beq_not_taken: got %h expected %h", {state_o, ctl}, {4'd9, CBr0});
    end
    step();
    opcode = OpJ;
    step(); step();
    checks++; if ({state_o, ctl} !== {4'd12, CJump}) begin
      errors++; $display("FAIL jump: got %h expected %h", {state_o, ctl}, {4'd12, CJump});
    end
    step();
    checks++; if ({state_o, retired} !== {4'd1, CntW'(6)}) begin
      errors++; $display("FAIL branch_retired: state %0d retired %0d expected 1/6", state_o,
                         retired);
    end
  endtask

  task automatic test_sw_wait();
    opcode = OpSw;
    step(); step();
    checks++; if ({state_o, ctl} !== {4'd3, CMemAdr}) begin
      errors++; $display("FAIL sw_memadr: got %h expected %h", {state_o, ctl}, {4'd3, CMemAdr});
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) mem_ready = 1'b1;
      #1;
      checks++; if ({state_o, ctl} !== {4'd6, CMemWr}) begin
        errors++; $display("FAIL sw_wait%0d: got %h expected %h", i, {state_o, ctl},
                           {4'd6, CMemWr});
      end
    end
    step();
    checks++; if ({state_o, MemWrite, retired} !== {4'd1, 1'b0, CntW'(7)}) begin
      errors++; $display("FAIL sw_done: state %0d memwrite %b retired %0d expected 1/0/7",
                         state_o, MemWrite, retired);
    end
  endtask

  task automatic test_fetch_stall();
    mem_ready = 1'b0;
    #1;
    checks++; if ({state_o, ctl} !== {4'd1, CFetchW}) begin
      errors++; $display("FAIL fetch_stall: got %h expected %h", {state_o, ctl}, {4'd1, CFetchW});
    end
    step();
    mem_ready = 1'b1;
    #1;
    checks++; if ({state_o, ctl} !== {4'd1, CFetch}) begin
      errors++; $display("FAIL fetch_resume: got %h expected %h", {state_o, ctl}, {4'd1, CFetch});
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    step();
    checks++; if ({state_o, illegal_op, ctl} !== {4'd2, 1'b1, CDecode}) begin
      errors++; $display("FAIL illegal_decode: got %h expected %h", {state_o, illegal_op, ctl},
                         {4'd2, 1'b1, CDecode});
    end
    step();
    checks++; if ({state_o, illegal_op, retired} !== {4'd1, 1'b0, CntW'(7)}) begin
      errors++; $display("FAIL illegal_after: state %0d pulse %b retired %0d expected 1/0/7",
                         state_o, illegal_op, retired);
    end
  endtask

  task automatic test_inhibit_reset();
    opcode = OpR;
    step(); step();
    wr_inhibit = 1'b1;
    step();
    checks++; if ({state_o, RegWrite, RegDst} !== {4'd8, 1'b0, 1'b1}) begin
      errors++; $display("FAIL inhibit_aluwb: got %h expected %h", {state_o, RegWrite, RegDst},
                         {4'd8, 1'b0, 1'b1});
    end
    step();
    checks++; if ({state_o, retired} !== {4'd1, CntW'(8)}) begin
      errors++; $display("FAIL inhibit_advance: state %0d retired %0d expected 1/8", state_o,
                         retired);
    end
    wr_inhibit = 1'b0;
    opcode = OpSw;
    step(); step();
    mem_ready = 1'b0;
    step();
    checks++; if ({state_o, MemWrite} !== {4'd6, 1'b1}) begin
      errors++; $display("FAIL pre_reset_memwr: got %h expected %h", {state_o, MemWrite},
                         {4'd6, 1'b1});
    end
    #2 reset = 1'b0;
    #1;
    checks++; if ({state_o, Start_PC, illegal_op, ctl} !== {4'd0, 1'b0, 1'b0, CZero}) begin
      errors++; $display("FAIL async_reset_outputs: got %h expected %h",
                         {state_o, Start_PC, illegal_op, ctl}, {4'd0, 1'b0, 1'b0, CZero});
    end
    checks++; if (retired !== '0) begin
      errors++; $display("FAIL async_reset_retired: got %0d expected 0", retired);
    end
    mem_ready = 1'b1;
    step();
    checks++; if ({state_o, ctl} !== {4'd0, CZero}) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", {state_o, ctl}, {4'd0, CZero});
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw_r_addi();
    test_branch_jump();
    test_sw_wait();
    test_fetch_stall();
    test_illegal();
    test_inhibit_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
